// File: rtl/threshold_pkg.sv
// Shared types for the threshold order issuer: zone codes, order payload and FSM states.
package threshold_pkg;

  typedef enum logic [1:0] {
    ZoneInvalid = 2'b00,
    ZoneBand    = 2'b01,
    ZoneLow     = 2'b10,
    ZoneHigh    = 2'b11
  } zone_t;

  typedef enum logic {
    SideBuy  = 1'b0,
    SideSell = 1'b1
  } side_t;

  typedef struct packed {
    side_t      side;
    logic [5:0] qty;
    logic [7:0] price;
  } order_t;

  typedef logic [0:0] state_t;
  localparam state_t StIdle     = 1'b0;
  localparam state_t StCooldown = 1'b1;

  // Symmetric position window check on the 9-bit candidate position.
  function automatic logic within_limit(input logic signed [8:0] pos_next,
                                        input int unsigned     max_pos);
    logic signed [8:0] lim;
    lim = $signed(9'(max_pos));
    return (pos_next <= lim) && (pos_next >= -lim);
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Power-of-two order FIFO; head is presented combinationally. Used when ORDER_QUEUE_EN is defined.
module order_fifo
  import threshold_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   push_i,
  input  order_t push_data_i,
  input  logic   pop_i,
  output order_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  order_t          mem_q [DEPTH];
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW:0]     count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Push while full is only allowed alongside a pop, so wptr equals the slot being freed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/threshold_order_issuer.sv
// Turns detector zone entries into rate- and position-limited orders on a valid/ready port.
// Define ORDER_QUEUE_EN to place a QUEUE_DEPTH-entry FIFO in front of the output.
module threshold_order_issuer
  import threshold_pkg::*;
#(
  parameter int unsigned ORDER_QTY       = 10,
  parameter int unsigned MAX_POSITION    = 50,
  parameter int unsigned COOLDOWN_CYCLES = 4,
  parameter int unsigned QUEUE_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] zone,
  input  logic [7:0] price,
  output logic       order_valid,
  input  logic       order_ready,
  output logic       order_side,
  output logic [5:0] order_qty,
  output logic [7:0] order_price,
  output logic [7:0] position,
  output logic [7:0] drop_count
);

  localparam int unsigned   CntW    = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(COOLDOWN_CYCLES);
  localparam logic [5:0]    Qty     = 6'(ORDER_QTY);

  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two >= 2");
  end
  if ((ORDER_QTY < 1) || (ORDER_QTY > 63) || (ORDER_QTY + MAX_POSITION > 127)) begin : g_bad_qty
    $error("ORDER_QTY must be 1..63 and ORDER_QTY + MAX_POSITION <= 127");
  end

  logic [1:0]        prev_zone_q;
  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic signed [7:0] pos_q;
  logic [7:0]        drop_count_q;

  logic              ev, ev_sell, limit_ok, slot_free, push, drop, pop;
  logic signed [8:0] pos_ext, qty_ext, pos_next;
  order_t            push_data, out;

  always_comb begin
    ev       = (zone != ZoneInvalid) && (zone != ZoneBand) && (zone != prev_zone_q);
    ev_sell  = (zone == ZoneHigh);
    pos_ext  = {pos_q[7], pos_q};
    qty_ext  = {3'b000, Qty};
    pos_next = ev_sell ? (pos_ext - qty_ext) : (pos_ext + qty_ext);
    limit_ok = within_limit(pos_next, MAX_POSITION);
    push     = ev && (state_q == StIdle) && limit_ok && slot_free;
    drop     = ev && !push;

    push_data.side  = ev_sell ? SideSell : SideBuy;
    push_data.qty   = Qty;
    push_data.price = price;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StCooldown) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) state_d = StIdle;
    end else if (push && (COOLDOWN_CYCLES != 0)) begin
      cnt_d   = CntLoad;
      state_d = StCooldown;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_zone_q  <= ZoneBand;
      state_q      <= StIdle;
      cnt_q        <= '0;
      pos_q        <= '0;
      drop_count_q <= '0;
    end else begin
      if (zone != ZoneInvalid) prev_zone_q <= zone;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Position commits when the order is queued, not when it is handed off.
      if (push) pos_q <= pos_next[7:0];
      if (drop && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign pop = order_valid && order_ready;

`ifdef ORDER_QUEUE_EN
  order_t head;
  logic   full, empty;

  order_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign slot_free   = !full || pop;
  assign order_valid = !empty;
  assign out         = order_valid ? head : '0;
`else
  order_t out_q;
  logic   valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (push) begin
      valid_q <= 1'b1;
      out_q   <= push_data;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign slot_free   = !valid_q || order_ready;
  assign order_valid = valid_q;
  assign out         = out_q;
`endif

  assign order_side  = out.side;
  assign order_qty   = out.qty;
  assign order_price = out.price;
  assign position    = pos_q;
  assign drop_count  = drop_count_q;

endmodule
